// File: rtl/stm_gain_stream_pkg.sv
// Shared constants and types for the STM gain streamer.
//   LANE_W        : bits per transducer entry (phase low byte, intensity high byte)
//   WORD_W_DEF    : default memory read width
//   STM_MODE_GAIN : STM mode code for gain streaming
//   gs_state_t    : streamer FSM states
//   clog2_min1()  : $clog2 clamped to at least 1 bit, for ports that may
//                   collapse to a single value (one word, one transducer)
package stm_gain_stream_pkg;

    localparam int   LANE_W        = 16;
    localparam int   WORD_W_DEF    = 64;
    localparam logic STM_MODE_GAIN = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } gs_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stm_gain_stream_if.sv
// Bus bundle between the gain streamer and its surroundings.
//   master : streamer view (control in, memory read port out, sample stream out)
//   slave  : environment view (drives START/SEGMENT/GAIN_IDX and MEM_VALUE)
interface stm_gain_stream_if
    import stm_gain_stream_pkg::*;
#(
    parameter int DEPTH  = 249,
    parameter int SIZE   = 1024,
    parameter int WORD_W = WORD_W_DEF
);
    localparam int LANES  = WORD_W / LANE_W;
    localparam int IDX_W  = clog2_min1(SIZE);
    localparam int ADDR_W = clog2_min1((DEPTH + LANES - 1) / LANES);
    localparam int TR_W   = clog2_min1(DEPTH);

    logic              START;
    logic              SEGMENT;
    logic [IDX_W-1:0]  GAIN_IDX;
    logic              BUSY;
    logic              MEM_SEGMENT;
    logic [IDX_W-1:0]  MEM_IDX;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [WORD_W-1:0] MEM_VALUE;
    logic              VALID;
    logic [TR_W-1:0]   TR_IDX;
    logic [7:0]        PHASE;
    logic [7:0]        INTENSITY;
    logic              DONE;

    modport master (
        input  START, SEGMENT, GAIN_IDX, MEM_VALUE,
        output BUSY, MEM_SEGMENT, MEM_IDX, MEM_ADDR,
               VALID, TR_IDX, PHASE, INTENSITY, DONE
    );

    modport slave (
        output START, SEGMENT, GAIN_IDX, MEM_VALUE,
        input  BUSY, MEM_SEGMENT, MEM_IDX, MEM_ADDR,
               VALID, TR_IDX, PHASE, INTENSITY, DONE
    );

endinterface

// File: rtl/stm_gain_lane_sel.sv
// Word buffer plus lane mux.
//   clk, rst : clock, async active-high reset
//   load     : memory word is valid this cycle; capture it
//   sel      : lane to present
//   word_in  : raw memory read data
//   lane     : selected 16-bit lane
// On the load cycle the live word is muxed directly so lane 0 leaves without
// waiting for the buffer; later lanes come from the captured copy, which lets
// the memory move on to the next address.
module stm_gain_lane_sel
    import stm_gain_stream_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int SEL_W  = clog2_min1(WORD_W / LANE_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [SEL_W-1:0]  sel,
    input  logic [WORD_W-1:0] word_in,
    output logic [LANE_W-1:0] lane
);
    localparam int LANES = WORD_W / LANE_W;

    logic [LANES-1:0][LANE_W-1:0] word_q;
    logic [LANES-1:0][LANE_W-1:0] src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       word_q <= '0;
        else if (load) word_q <= word_in;
    end

    always_comb begin
        src  = load ? word_in : word_q;
        lane = '0;
        for (int k = 0; k < LANES; k++)
            if (sel == SEL_W'(k)) lane = src[k];
    end

endmodule

// File: rtl/stm_gain_stream.sv
// Streams one STM gain (DEPTH transducers) out of the gain BRAM read port,
// one sample per cycle.
//   CLK, RST : clock, async active-high reset
//   bus      : master side of stm_gain_stream_if
//              START/SEGMENT/GAIN_IDX -> request, BUSY while streaming
//              MEM_SEGMENT/MEM_IDX/MEM_ADDR -> memory, MEM_VALUE <- memory
//              VALID/TR_IDX/PHASE/INTENSITY -> samples, DONE with the last one
// A new word address is issued every LANES cycles; vld_pipe tracks each issue
// through the fixed read latency so the word is captured exactly when it
// returns, and its lanes drain back-to-back until the next word lands.
module stm_gain_stream
    import stm_gain_stream_pkg::*;
#(
    parameter int DEPTH        = 249,
    parameter int SIZE         = 1024,
    parameter int WORD_W       = WORD_W_DEF,
    parameter int READ_LATENCY = 2
) (
    input  logic CLK,
    input  logic RST,
    stm_gain_stream_if.master bus
);
    localparam int LANES     = WORD_W / LANE_W;
    localparam int NWORDS    = (DEPTH + LANES - 1) / LANES;
    localparam int ADDR_W    = clog2_min1(NWORDS);
    localparam int TR_W      = clog2_min1(DEPTH);
    localparam int SEL_W     = clog2_min1(LANES);
    localparam int LAST_WORD = NWORDS - 1;

    gs_state_t               state;
    logic [SEL_W-1:0]        fetch_lane;
    logic [READ_LATENCY:0]   vld_pipe;
    logic                    em_act;
    logic [SEL_W-1:0]        em_lane;
    logic [TR_W-1:0]         tr_cnt;
    logic                    load;
    logic                    emit;
    logic                    last;
    logic [SEL_W-1:0]        sel;
    logic [LANE_W-1:0]       lane;

    assign load = vld_pipe[READ_LATENCY];
    assign emit = load | em_act;
    assign sel  = load ? '0 : em_lane;
    assign last = (tr_cnt == TR_W'(DEPTH - 1));

    stm_gain_lane_sel #(.WORD_W(WORD_W), .SEL_W(SEL_W)) u_lane_sel (
        .clk     (CLK),
        .rst     (RST),
        .load    (load),
        .sel     (sel),
        .word_in (bus.MEM_VALUE),
        .lane    (lane)
    );

    // Control FSM and memory address side.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state           <= ST_IDLE;
            bus.BUSY        <= 1'b0;
            bus.MEM_SEGMENT <= 1'b0;
            bus.MEM_IDX     <= '0;
            bus.MEM_ADDR    <= '0;
            fetch_lane      <= '0;
            vld_pipe        <= '0;
        end else begin
            vld_pipe[READ_LATENCY:1] <= vld_pipe[READ_LATENCY-1:0];
            vld_pipe[0]              <= 1'b0;
            case (state)
                ST_IDLE: if (bus.START) begin
                    state           <= ST_FETCH;
                    bus.BUSY        <= 1'b1;
                    bus.MEM_SEGMENT <= bus.SEGMENT;
                    bus.MEM_IDX     <= bus.GAIN_IDX;
                    bus.MEM_ADDR    <= '0;
                    fetch_lane      <= '0;
                    vld_pipe[0]     <= 1'b1;
                end
                ST_FETCH: begin
                    // Last address has been presented for one cycle; its data
                    // is still in flight, so hand over to DRAIN.
                    if (bus.MEM_ADDR == ADDR_W'(LAST_WORD)) begin
                        state <= ST_DRAIN;
                    end else if (fetch_lane == SEL_W'(LANES - 1)) begin
                        bus.MEM_ADDR <= bus.MEM_ADDR + ADDR_W'(1);
                        fetch_lane   <= '0;
                        vld_pipe[0]  <= 1'b1;
                    end else begin
                        fetch_lane <= fetch_lane + SEL_W'(1);
                    end
                end
                ST_DRAIN: if (bus.DONE) begin
                    state    <= ST_IDLE;
                    bus.BUSY <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.BUSY <= 1'b0;
                end
            endcase
        end
    end

    // Sample side: one lane per cycle, outputs hold when idle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.VALID     <= 1'b0;
            bus.DONE      <= 1'b0;
            bus.TR_IDX    <= '0;
            bus.PHASE     <= '0;
            bus.INTENSITY <= '0;
            em_act        <= 1'b0;
            em_lane       <= '0;
            tr_cnt        <= '0;
        end else begin
            bus.VALID <= emit;
            bus.DONE  <= emit & last;
            if (emit) begin
                bus.TR_IDX                   <= tr_cnt;
                {bus.INTENSITY, bus.PHASE}   <= lane;
                if (last) begin
                    // Remaining lanes of a partial last word are dropped here.
                    em_act <= 1'b0;
                    tr_cnt <= '0;
                end else begin
                    tr_cnt <= tr_cnt + TR_W'(1);
                    if (sel == SEL_W'(LANES - 1)) begin
                        em_act <= 1'b0;   // next word lands next cycle
                    end else begin
                        em_act  <= 1'b1;
                        em_lane <= sel + SEL_W'(1);
                    end
                end
            end
        end
    end

endmodule
